// File: rtl/fifo_2c_push_arb.sv
// Push-side controller for the dual-clock FIFO (clk_s domain).
// Round-robin arbitration of num_req producers onto the single FIFO push port,
// with bounded bursts, full/almost-full back-pressure and a source-initiated
// clear sequence (clr_s pulse, then wait for clr_cmplt_s).
module fifo_2c_push_arb #(
  parameter int width     = 8,
  parameter int num_req   = 4,
  parameter int burst_len = 4
) (
  input  logic                     clk_s,
  input  logic                     rst_s_n,
  input  logic [num_req-1:0]       req_valid,
  input  logic [num_req*width-1:0] req_data,
  output logic [num_req-1:0]       req_ready,
  output logic [num_req-1:0]       grant,
  input  logic                     flush_req,
  output logic                     flush_done,
  output logic                     push_s_n,
  output logic [width-1:0]         data_s,
  output logic                     clr_s,
  input  logic                     full_s,
  input  logic                     almost_full_s,
  input  logic                     clr_in_prog_s,
  input  logic                     clr_cmplt_s
);

  localparam int IW = (num_req > 1) ? $clog2(num_req) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, CLR_REQ, CLR_WAIT} state_t;

  state_t               state_q, state_d;
  logic [num_req-1:0]   grant_q, grant_d;
  logic [IW-1:0]        own_q, own_d;
  logic [IW-1:0]        rr_q, rr_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 pend_q, pend_d;
  logic                 done_q, done_d;

  logic [IW-1:0]        pick;
  logic                 pick_ok;
  logic [width-1:0]     data_mux;
  logic                 own_valid;
  logic                 accept;
  logic                 burst_end;

  // Round-robin search: first valid requester at or above rr_q, wrapping.
  // Walking the offsets downwards lets the lowest offset win.
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    for (int k = num_req - 1; k >= 0; k--) begin
      int j;
      j = int'(rr_q) + k;
      if (j >= num_req) j = j - num_req;
      if (req_valid[j]) begin
        pick    = IW'(j);
        pick_ok = 1'b1;
      end
    end
  end

  // Owner data/valid select; zero data when nobody holds the grant.
  always_comb begin
    data_mux  = '0;
    own_valid = 1'b0;
    for (int i = 0; i < num_req; i++) begin
      if (grant_q[i]) begin
        data_mux  = data_mux | req_data[i*width +: width];
        own_valid = own_valid | req_valid[i];
      end
    end
  end

  // A word moves only while granted, owner valid, FIFO not full and no clear
  // in progress anywhere; full_s alone stalls without closing the burst.
  assign accept    = (state_q == GRANT) & own_valid & ~full_s & ~clr_in_prog_s;
  assign burst_end = (accept & (cnt_q == 4'(burst_len - 1)))
                   | ~own_valid
                   | (accept & almost_full_s)
                   | pend_q;

  assign push_s_n   = ~accept;
  assign req_ready  = grant_q & {num_req{accept}};
  assign grant      = grant_q;
  assign data_s     = data_mux;
  assign clr_s      = (state_q == CLR_REQ);
  assign flush_done = done_q;

  // Next-state logic for the arbitration/clear FSM and its bookkeeping.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    own_d   = own_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    pend_d  = pend_q;
    // Flush requests arriving once a clear is under way are absorbed.
    if (flush_req && (state_q == IDLE || state_q == GRANT)) pend_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (pend_q) begin
          state_d = CLR_REQ;
          pend_d  = 1'b0;
        end else if (!clr_in_prog_s && pick_ok) begin
          state_d       = GRANT;
          own_d         = pick;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          cnt_d         = '0;
        end
      end
      GRANT: begin
        if (accept) cnt_d = cnt_q + 4'd1;
        if (burst_end) begin
          state_d = IDLE;
          grant_d = '0;
          rr_d    = (own_q == IW'(num_req - 1)) ? '0 : own_q + 1'b1;
        end
      end
      CLR_REQ: state_d = CLR_WAIT;
      CLR_WAIT: begin
        if (clr_cmplt_s) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and control registers; reset drops any in-flight burst or clear.
  always_ff @(posedge clk_s or negedge rst_s_n) begin
    if (!rst_s_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      own_q   <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      own_q   <= own_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_fifo_2c_push_arb.sv
// Self-checking bench for fifo_2c_push_arb: directed scenarios plus randomized
// traffic compared cycle by cycle against a behavioural model of the rules.
module tb_fifo_2c_push_arb;
  localparam int W  = 8;
  localparam int NR = 4;
  localparam int BL = 4;

  localparam int M_IDLE = 0, M_GRANT = 1, M_CLR_REQ = 2, M_CLR_WAIT = 3;

  logic              clk_s = 1'b0;
  logic              rst_s_n = 1'b0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR*W-1:0]   req_data = '0;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     grant;
  logic              flush_req = 1'b0;
  logic              flush_done;
  logic              push_s_n;
  logic [W-1:0]      data_s;
  logic              clr_s;
  logic              full_s = 1'b0;
  logic              almost_full_s = 1'b0;
  logic              clr_in_prog_s = 1'b0;
  logic              clr_cmplt_s = 1'b0;

  always #5 clk_s = ~clk_s;

  fifo_2c_push_arb #(.width(W), .num_req(NR), .burst_len(BL)) dut (
    .clk_s(clk_s), .rst_s_n(rst_s_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .grant(grant), .flush_req(flush_req),
    .flush_done(flush_done), .push_s_n(push_s_n), .data_s(data_s), .clr_s(clr_s),
    .full_s(full_s), .almost_full_s(almost_full_s), .clr_in_prog_s(clr_in_prog_s),
    .clr_cmplt_s(clr_cmplt_s)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Behavioural model: who owns the port, how many words moved, where the
  // round-robin search restarts, and where the clear sequence stands.
  int m_mode, m_own, m_rr, m_words;
  bit m_pend, m_done;

  task automatic model_reset();
    m_mode = M_IDLE; m_own = -1; m_rr = 0; m_words = 0; m_pend = 0; m_done = 0;
  endtask

  function automatic bit m_accept();
    if (m_mode != M_GRANT) return 1'b0;
    return req_valid[m_own] && !full_s && !clr_in_prog_s;
  endfunction

  task automatic model_update();
    bit acc, pend_in, last;
    int mode;
    acc = m_accept(); pend_in = m_pend; mode = m_mode;
    m_done = (mode == M_CLR_WAIT) && clr_cmplt_s;
    if (flush_req && (mode == M_IDLE || mode == M_GRANT)) m_pend = 1;
    case (mode)
      M_IDLE: begin
        if (pend_in) begin
          m_mode = M_CLR_REQ; m_pend = 0;
        end else if (!clr_in_prog_s && req_valid != 0) begin
          for (int k = NR - 1; k >= 0; k--)
            if (req_valid[(m_rr + k) % NR]) m_own = (m_rr + k) % NR;
          m_words = 0; m_mode = M_GRANT;
        end
      end
      M_GRANT: begin
        last = acc && (m_words + 1 == BL);
        if (acc) m_words++;
        if (last || !req_valid[m_own] || (acc && almost_full_s) || pend_in) begin
          m_rr = (m_own + 1) % NR; m_mode = M_IDLE; m_own = -1;
        end
      end
      M_CLR_REQ: m_mode = M_CLR_WAIT;
      default: if (clr_cmplt_s) m_mode = M_IDLE;
    endcase
  endtask

  // Sampled outputs and observation counters for the directed scenarios.
  logic [NR-1:0] s_grant, s_ready, last_g;
  logic [W-1:0]  s_data;
  logic          s_push, s_clr, s_done;
  int n_push, n_clr, n_done;
  int owner_log[$];

  task automatic compare_outputs();
    bit acc;
    logic [NR-1:0] g;
    logic [W-1:0] d;
    acc = m_accept();
    g = '0; d = '0;
    if (m_mode == M_GRANT) begin
      g[m_own] = 1'b1;
      d = req_data[m_own*W +: W];
    end
    check_eq("grant", grant, g);
    check_eq("push_s_n", push_s_n, !acc);
    check_eq("req_ready", req_ready, acc ? g : '0);
    check_eq("data_s", data_s, d);
    check_eq("clr_s", clr_s, m_mode == M_CLR_REQ);
    check_eq("flush_done", flush_done, m_done);
  endtask

  task automatic tick();
    for (int i = 0; i < NR; i++) req_data[i*W +: W] = W'($urandom_range(0, 255));
    #1;
    if (!rst_s_n) model_reset();
    compare_outputs();
    s_grant = grant; s_ready = req_ready; s_data = data_s;
    s_push = push_s_n; s_clr = clr_s; s_done = flush_done;
    if (!push_s_n) n_push++;
    if (clr_s) n_clr++;
    if (flush_done) n_done++;
    if (grant != 0 && grant != last_g)
      for (int i = 0; i < NR; i++) if (grant[i]) owner_log.push_back(i);
    last_g = grant;
    @(posedge clk_s);
    if (rst_s_n) model_update();
    @(negedge clk_s);
  endtask

  task automatic drive(input logic [NR-1:0] v, input bit f, input bit af,
                       input bit cip, input bit fr, input bit cc);
    req_valid = v; full_s = f; almost_full_s = af;
    clr_in_prog_s = cip; flush_req = fr; clr_cmplt_s = cc;
  endtask

  initial begin
    int exp_order[5] = '{0, 1, 2, 3, 0};
    model_reset();
    last_g = '0;
    @(negedge clk_s);

    // Reset values with all producers requesting.
    rst_s_n = 1'b0;
    drive(4'hF, 0, 0, 0, 0, 0);
    tick();
    check_eq("rst_push", s_push, 1'b1);
    check_eq("rst_clr", s_clr, 1'b0);
    check_eq("rst_grant", s_grant, '0);
    check_eq("rst_ready", s_ready, '0);
    check_eq("rst_data", s_data, '0);

    // All four valid, no back-pressure: 0,1,2,3,0 with four words each.
    rst_s_n = 1'b1;
    owner_log.delete(); n_push = 0;
    repeat (21) tick();
    check_eq("rr_pushes", n_push, 16);
    tick();
    check_eq("rr_order_len", owner_log.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < owner_log.size()) check_eq("rr_order", owner_log[i], exp_order[i]);

    // Close owner 0's burst, then owner 1 stalls on full, ends on almost-full.
    drive(4'h0, 0, 0, 0, 0, 0); tick();
    drive(4'hF, 0, 0, 0, 0, 0); tick(); tick();
    drive(4'hF, 1, 0, 0, 0, 0); tick();
    check_eq("full_stall_push", s_push, 1'b1);
    check_eq("full_stall_grant", s_grant, 4'b0010);
    tick(); tick();
    drive(4'hF, 0, 1, 0, 0, 0); tick();
    check_eq("af_push", s_push, 1'b0);
    drive(4'hF, 0, 0, 0, 0, 0); tick();
    check_eq("af_gap", s_grant, '0);
    tick();
    check_eq("af_next_owner", s_grant, 4'b0100);

    // Flush in the middle of owner 0's burst; a second request is absorbed.
    drive(4'b0001, 0, 0, 0, 0, 0); tick(); tick(); tick();
    check_eq("flush_owner", s_grant, 4'b0001);
    n_clr = 0; n_done = 0;
    drive(4'b0001, 0, 0, 0, 1, 0); tick();
    drive(4'b0001, 0, 0, 0, 0, 0); tick(); tick(); tick();
    check_eq("clr_pulse", s_clr, 1'b1);
    drive(4'hF, 0, 0, 0, 1, 0); tick();
    drive(4'hF, 0, 0, 0, 0, 0); repeat (5) tick();
    drive(4'hF, 0, 0, 0, 0, 1); tick();
    drive(4'hF, 0, 0, 0, 0, 0); tick();
    check_eq("flush_done_pulse", s_done, 1'b1);
    tick();
    check_eq("after_flush_owner", s_grant, 4'b0010);
    repeat (3) tick();
    check_eq("clr_count", n_clr, 1);
    check_eq("done_count", n_done, 1);

    // Remote clear in progress: nothing moves while it is high.
    n_push = 0;
    drive(4'hF, 0, 0, 1, 0, 0); repeat (5) tick();
    check_eq("remote_clr_pushes", n_push, 0);
    drive(4'hF, 0, 0, 0, 0, 0); repeat (3) tick();

    // Reset while waiting for clear completion.
    drive(4'hF, 0, 0, 0, 1, 0); tick();
    drive(4'hF, 0, 0, 0, 0, 0); repeat (4) tick();
    rst_s_n = 1'b0; tick();
    check_eq("rst_wait_clr", s_clr, 1'b0);
    check_eq("rst_wait_grant", s_grant, '0);
    check_eq("rst_wait_push", s_push, 1'b1);
    rst_s_n = 1'b1; tick(); tick();
    check_eq("rst_rr_zero", s_grant, 4'b0001);

    // Reset mid-burst with a flush pending: the flush is lost.
    drive(4'hF, 0, 0, 0, 1, 0); tick();
    drive(4'hF, 0, 0, 0, 0, 0);
    rst_s_n = 1'b0; tick();
    check_eq("rst_burst_grant", s_grant, '0);
    rst_s_n = 1'b1; n_clr = 0;
    repeat (8) tick();
    check_eq("lost_flush", n_clr, 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst_s_n = ($urandom_range(0, 299) != 0);
      drive(NR'($urandom_range(0, 15)) | (($urandom_range(0, 3) != 0) ? 4'hF : 4'h0) &
            NR'($urandom_range(0, 15)),
            $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 4) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
